// File: rtl/vm_dispenser.sv
// Vending machine dispenser: drives the product motor for a fixed time, then
// pays owed change greedily (5/2/1) through a coin hopper with stall timeout.
//
// state  | meaning
// IDLE   | waiting for a vend request, disp_ready high
// VEND   | product motor on for VEND_CYCLES cycles
// CHANGE | ejecting coins while hopper_ready, counting stall cycles
// DONE   | one-cycle completion pulse
// FAULT  | hopper timed out; held until reset
module vm_dispenser #(
  parameter int unsigned VEND_CYCLES    = 4,
  parameter int unsigned HOPPER_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_valid,
  input  logic [1:0] disp_item,
  input  logic [3:0] disp_change,
  input  logic       hopper_ready,
  output logic       disp_ready,
  output logic [1:0] item_out,
  output logic       item_strobe,
  output logic       coin_strobe,
  output logic [1:0] coin_sel,
  output logic       done,
  output logic       fault,
  output logic [7:0] coins_total
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VEND   = 3'd1;
  localparam logic [2:0] S_CHANGE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [3:0] VEND_LOAD   = 4'(VEND_CYCLES - 1);
  localparam logic [8:0] STALL_LIMIT = 9'(HOPPER_TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [1:0] item_q, item_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] vend_cnt_q, vend_cnt_d;
  logic [7:0] stall_q, stall_d;
  logic [7:0] coins_q, coins_d;

  logic       coin_fire;
  logic [1:0] sel_raw;
  logic [3:0] coin_val;
  logic [8:0] stall_next;

  // Greedy pick from the current remainder, so coin_val never exceeds rem_q.
  always_comb begin
    sel_raw  = 2'd1;
    coin_val = 4'd1;
    if (rem_q >= 4'd5) begin
      sel_raw  = 2'd3;
      coin_val = 4'd5;
    end else if (rem_q >= 4'd2) begin
      sel_raw  = 2'd2;
      coin_val = 4'd2;
    end
  end

  assign coin_fire  = (state_q == S_CHANGE) && hopper_ready && (rem_q != 4'd0);
  assign stall_next = {1'b0, stall_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    rem_d      = rem_q;
    vend_cnt_d = vend_cnt_q;
    stall_d    = stall_q;
    coins_d    = coins_q;
    case (state_q)
      S_IDLE: begin
        if (disp_valid) begin
          item_d     = disp_item;
          rem_d      = disp_change;
          vend_cnt_d = VEND_LOAD;
          stall_d    = 8'd0;
          if (disp_item != 2'd0) begin
            state_d = S_VEND;
          end else if (disp_change != 4'd0) begin
            state_d = S_CHANGE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_VEND: begin
        if (vend_cnt_q == 4'd0) begin
          state_d = (rem_q != 4'd0) ? S_CHANGE : S_DONE;
        end else begin
          vend_cnt_d = vend_cnt_q - 4'd1;
        end
      end
      S_CHANGE: begin
        if (coin_fire) begin
          rem_d   = rem_q - coin_val;
          coins_d = coins_q + 8'd1;
          stall_d = 8'd0;
          if (rem_d == 4'd0) begin
            state_d = S_DONE;
          end
        end else if (!hopper_ready) begin
          stall_d = stall_next[7:0];
          if (stall_next == STALL_LIMIT) begin
            state_d = S_FAULT;
          end
        end else begin
          stall_d = 8'd0;
        end
      end
      S_DONE: begin
        item_d  = 2'd0;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      item_q     <= 2'd0;
      rem_q      <= 4'd0;
      vend_cnt_q <= 4'd0;
      stall_q    <= 8'd0;
      coins_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      rem_q      <= rem_d;
      vend_cnt_q <= vend_cnt_d;
      stall_q    <= stall_d;
      coins_q    <= coins_d;
    end
  end

  assign disp_ready  = (state_q == S_IDLE);
  assign item_strobe = (state_q == S_VEND);
  assign item_out    = (state_q == S_VEND) ? item_q : 2'd0;
  assign coin_strobe = coin_fire;
  assign coin_sel    = coin_fire ? sel_raw : 2'd0;
  assign done        = (state_q == S_DONE);
  assign fault       = (state_q == S_FAULT);
  assign coins_total = coins_q;

endmodule

// File: tb/tb_vm_dispenser.sv
// Scoreboard bench for vm_dispenser: stimulus pushes time-stamped expected
// strobe/done events, a negedge monitor pops and compares them.
module tb_vm_dispenser;

  logic       clk;
  logic       rst;
  logic       disp_valid;
  logic [1:0] disp_item;
  logic [3:0] disp_change;
  logic       hopper_ready;
  logic       disp_ready;
  logic [1:0] item_out;
  logic       item_strobe;
  logic       coin_strobe;
  logic [1:0] coin_sel;
  logic       done;
  logic       fault;
  logic [7:0] coins_total;

  vm_dispenser dut (
    .clk         (clk),
    .rst         (rst),
    .disp_valid  (disp_valid),
    .disp_item   (disp_item),
    .disp_change (disp_change),
    .hopper_ready(hopper_ready),
    .disp_ready  (disp_ready),
    .item_out    (item_out),
    .item_strobe (item_strobe),
    .coin_strobe (coin_strobe),
    .coin_sel    (coin_sel),
    .done        (done),
    .fault       (fault),
    .coins_total (coins_total)
  );

  // kind: 1 = item strobe (val = item_out), 2 = coin (val = coin_sel), 3 = done (val = coins_total)
  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t a;
    ev_t e;
    if (rst && (item_strobe || coin_strobe || done)) begin
      a.cyc = cyc;
      if (done) begin
        a.kind = 3;
        a.val  = int'(coins_total);
      end else if (coin_strobe) begin
        a.kind = 2;
        a.val  = int'(coin_sel);
      end else begin
        a.kind = 1;
        a.val  = int'(item_out);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d kind=%0d val=%0d required=no event", a.cyc, a.kind, a.val);
      end else begin
        e = exp_q.pop_front();
        if (a.cyc != e.cyc || a.kind != e.kind || a.val != e.val) begin
          failures++;
          $display("FAIL event cyc/kind/val actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                   a.cyc, a.kind, a.val, e.cyc, e.kind, e.val);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int c, input int kind, input int val);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_items(input int a, input int item);
    for (int i = 0; i < 4; i++) push(a + i, 1, item);
  endtask

  // Returns with cyc == accept edge number, #1 after that edge.
  task automatic accept(input logic [1:0] item, input logic [3:0] chg, output int a);
    @(posedge clk);
    #1;
    check("disp_ready_before_accept", int'(disp_ready), 1);
    a           = cyc + 1;
    disp_valid  = 1'b1;
    disp_item   = item;
    disp_change = chg;
    @(posedge clk);
    #1;
    disp_valid  = 1'b0;
    disp_item   = 2'd0;
    disp_change = 4'd0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp_ready"}, int'(disp_ready), 1);
    check({tag, "_item_out"}, int'(item_out), 0);
    check({tag, "_item_strobe"}, int'(item_strobe), 0);
    check({tag, "_coin_strobe"}, int'(coin_strobe), 0);
    check({tag, "_coin_sel"}, int'(coin_sel), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fault"}, int'(fault), 0);
    check({tag, "_coins_total"}, int'(coins_total), 0);
  endtask

  initial begin
    int a;
    rst          = 1'b0;
    disp_valid   = 1'b0;
    disp_item    = 2'd0;
    disp_change  = 4'd0;
    hopper_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // item 1, change 3: 4 vend cycles, coins 2 then 1, done with total 2
    accept(2'd1, 4'd3, a);
    push_items(a, 1);
    push(a + 4, 2, 2);
    push(a + 5, 2, 1);
    push(a + 6, 3, 2);
    drain("drain_item1_change3", 40);

    // item 0, change 13: coins 5,5,2,1 from the accept cycle, total 6
    accept(2'd0, 4'd13, a);
    push(a, 2, 3);
    push(a + 1, 2, 3);
    push(a + 2, 2, 2);
    push(a + 3, 2, 1);
    push(a + 4, 3, 6);
    drain("drain_item0_change13", 40);

    // item 2, change 0: vend only, no coins
    accept(2'd2, 4'd0, a);
    push_items(a, 2);
    push(a + 4, 3, 6);
    drain("drain_item2_change0", 40);

    // change 4 with a 3-cycle hopper stall between the two 2-unit coins
    accept(2'd0, 4'd4, a);
    push(a, 2, 2);
    push(a + 4, 2, 2);
    push(a + 5, 3, 8);
    @(posedge clk);
    #1;
    hopper_ready = 1'b0;
    @(posedge clk);
    #1;
    check("stall_coin_strobe", int'(coin_strobe), 0);
    check("stall_fault", int'(fault), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    hopper_ready = 1'b1;
    drain("drain_change4_stall", 40);
    check("stall_fault_after_done", int'(fault), 0);

    // request presented during VEND is ignored; reset mid-CHANGE aborts
    accept(2'd3, 4'd13, a);
    push_items(a, 3);
    push(a + 4, 2, 3);
    @(posedge clk);
    #1;
    disp_valid  = 1'b1;
    disp_item   = 2'd1;
    disp_change = 4'd0;
    @(posedge clk);
    #1;
    check("busy_disp_ready", int'(disp_ready), 0);
    @(posedge clk);
    #1;
    disp_valid  = 1'b0;
    disp_item   = 2'd0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_abort_coin_strobe", int'(coin_strobe), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_abort_disp_ready", int'(disp_ready), 1);
    check("post_abort_coins_total", int'(coins_total), 0);

    // change 5 with hopper held low: FAULT after 16 CHANGE cycles, sticky
    hopper_ready = 1'b0;
    accept(2'd0, 4'd5, a);
    repeat (15) @(posedge clk);
    #1;
    check("timeout_cycle15_fault", int'(fault), 0);
    @(posedge clk);
    #1;
    check("timeout_cycle16_fault", int'(fault), 1);
    check("timeout_disp_ready", int'(disp_ready), 0);
    hopper_ready = 1'b1;
    disp_valid   = 1'b1;
    disp_item    = 2'd1;
    disp_change  = 4'd1;
    repeat (10) @(posedge clk);
    #1;
    check("fault_sticky", int'(fault), 1);
    check("fault_disp_ready", int'(disp_ready), 0);
    check("fault_coin_strobe", int'(coin_strobe), 0);
    check("fault_item_strobe", int'(item_strobe), 0);
    rst = 1'b0;
    disp_valid = 1'b0;
    #1;
    check("fault_cleared", int'(fault), 0);
    check("fault_reset_disp_ready", int'(disp_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
